mul_share_arb: RTL

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_8x8_pipline.sv | 34 +++
 rtl/mul_share_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the shared 8x8 multiplier arbiter.
// The requester count, operand/product widths and pipeline latency live here.
package mul_pkg;

    localparam int N_REQ       = 4;
    localparam int ID_W        = 2;
    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;

    // Structural depth of mul_8x8_pipline: operand, product and output registers.
    localparam int MUL_8X8_LAT = 3;
    localparam int MUL_LAT     = MUL_8X8_LAT;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_8x8_pipline.sv
// Three-stage pipelined unsigned 8x8 multiplier: registers operands, product, then output.
// Latency from operand presentation to product is MUL_8X8_LAT cycles.
module mul_8x8_pipline
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            p_q    <= '0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= PROD_W'(a_q) * PROD_W'(b_q);
            p_q    <= prod_q;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among N_REQ requesters.
// A tag pipeline tracks which requester owns each product as it emerges.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int N_REQ   = mul_pkg::N_REQ,
    parameter int MUL_LAT = mul_pkg::MUL_LAT
) (
    input  logic                  clk_mul8x8,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_rdy,
    input  logic                  hold,
    output logic                  res_vld,
    output logic [ID_W-1:0]       res_id,
    output logic [PROD_W-1:0]     res_dout,
    output logic                  busy
);

    // The tag pipeline depth must track the multiplier's real latency.
    if (MUL_LAT != MUL_8X8_LAT) begin : g_bad_lat
        $error("mul_share_arb: MUL_LAT=%0d does not match mul_8x8_pipline latency %0d",
               MUL_LAT, MUL_8X8_LAT);
    end
    if (N_REQ != (1 << ID_W)) begin : g_bad_nreq
        $error("mul_share_arb: N_REQ=%0d does not fit ID_W=%0d", N_REQ, ID_W);
    end

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              grant_any;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_p;
    logic              mul_rst_n;
    tag_t              tag_q [MUL_LAT];

    // Search from ptr with wraparound; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_rdy   = '0;
        if (!rst && !hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = ID_W'((int'(ptr_q) + k) % N_REQ);
                if (!grant_any && req_vld[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            req_rdy[grant_idx] = 1'b1;
        end
    end

    assign mul_a = grant_any ? req_a[int'(grant_idx)*OP_W +: OP_W] : '0;
    assign mul_b = grant_any ? req_b[int'(grant_idx)*OP_W +: OP_W] : '0;

    always_ff @(posedge clk_mul8x8) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= ID_W'((int'(grant_idx) + 1) % N_REQ);
        end
    end

    // Tags advance in lockstep with the multiplier so ownership lines up with the product.
    always_ff @(posedge clk_mul8x8) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: grant_any, id: grant_idx};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            busy = busy | tag_q[i].vld;
        end
        busy = busy & ~rst;
    end

    assign res_vld   = tag_q[MUL_LAT-1].vld & ~rst;
    assign res_id    = tag_q[MUL_LAT-1].id;
    assign res_dout  = mul_p;
    assign mul_rst_n = ~rst;

    mul_8x8_pipline u_mul (
        .clk   (clk_mul8x8),
        .rst_n (mul_rst_n),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

endmodule
